// File: rtl/pwm_audio_sample_sequencer.sv
// Stereo sample-pair FIFO feeding PWM duty registers, one pair per RATE_DIV PWM periods; a popped pair shows up as the period counter wraps to 0.
// Upstream backpressure: s_ready drops only when the FIFO is full; an empty FIFO at a sample boundary holds the outputs and raises sticky underflow.
module pwm_audio_sample_sequencer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int RATE_DIV    = 1
) (
    input  logic                     clk,
    input  logic                     aclr,
    input  logic                     enable,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_left,
    input  logic [WIDTH-1:0]         s_right,
    output logic [WIDTH-1:0]         left_top,
    output logic [WIDTH-1:0]         right_top,
    output logic                     sample_tick,
    output logic                     underflow,
    input  logic                     underflow_clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     playing
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] period_cnt;
    logic [DW-1:0]    div_cnt;
    logic [WIDTH-1:0] mem_left  [DEPTH];
    logic [WIDTH-1:0] mem_right [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             starve;
    logic             period_wrap;
    logic             div_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign period_wrap = (period_cnt == '1);
    assign div_last    = (div_cnt == DW'(RATE_DIV - 1));
    assign sample_tick = enable && period_wrap && div_last;
    assign s_ready     = (level < LW'(DEPTH));
    assign push        = s_valid && s_ready;
    assign playing     = (state == ST_PLAY);

    always_comb begin
        pop    = 1'b0;
        starve = 1'b0;
        if (sample_tick) begin
            if (state == ST_PRIME && level >= LW'(PRIME_LEVEL)) begin
                pop = 1'b1;
            end
            if (state == ST_PLAY) begin
                if (level != '0) begin
                    pop = 1'b1;
                end else begin
                    starve = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            period_cnt <= '0;
            div_cnt    <= '0;
        end else if (!enable) begin
            period_cnt <= '0;
            div_cnt    <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
            if (period_wrap) begin
                div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_left[wr_ptr]  <= s_left;
            mem_right[wr_ptr] <= s_right;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= ST_IDLE;
            left_top  <= '0;
            right_top <= '0;
            underflow <= 1'b0;
        end else begin
            if (!enable) begin
                state     <= ST_IDLE;
                left_top  <= '0;
                right_top <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_PRIME;
                        left_top  <= '0;
                        right_top <= '0;
                    end
                    ST_PRIME: if (pop)    state <= ST_PLAY;
                    ST_PLAY:  if (starve) state <= ST_PRIME;
                    default:  state <= ST_IDLE;
                endcase
                if (pop) begin
                    left_top  <= mem_left[rd_ptr];
                    right_top <= mem_right[rd_ptr];
                end
            end
            if (starve) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
